// File: rtl/kernel_mem_pkg.sv
// kernel_mem_pkg: shared FSM/fill-mode types and sizing helpers for the banked kernel store.
package kernel_mem_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
   typedef enum logic {MODE_INTERLEAVE = 1'b0, MODE_SEQUENTIAL = 1'b1} mode_t;
   function automatic int log2_banks(input int n);
      return (n > 1) ? $clog2(n) : 0;
   endfunction
   function automatic int len_width(input int n, input int aw);
      return $clog2(n * (2 ** aw)) + 1;
   endfunction
endpackage

// File: rtl/kernel_bank.sv
// kernel_bank: inferred simple-dual-port RAM, one write port and one registered read port.
module kernel_bank #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
   always_ff @(posedge i_clock)
      if (i_we) mem[i_waddr] <= i_wdata;
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) o_rdata <= '0;
      else if (i_re) o_rdata <= mem[i_raddr];
endmodule

// File: rtl/kernel_mem_loader.sv
// kernel_mem_loader: banked kernel-weight store with a streaming loader that scatters
// incoming words across the banks, interleaved or bank-by-bank.
module kernel_mem_loader
   import kernel_mem_pkg::*;
#(
   parameter int KERNEL_BRAM_NUM = 4,
   parameter int KERNEL_BRAM_ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int READ_LATENCY = 2,
   localparam int LEN_WIDTH = len_width(KERNEL_BRAM_NUM, KERNEL_BRAM_ADDRESS_WIDTH)
)(
   input  logic                                 i_clock,
   input  logic                                 i_reset,
   input  logic                                 i_load_start,
   input  logic                                 i_load_mode,
   input  logic [LEN_WIDTH-1:0]                 i_load_len,
   input  logic                                 i_wvalid,
   output logic                                 o_wready,
   input  logic [DATA_WIDTH-1:0]                i_wdata,
   output logic                                 o_busy,
   output logic                                 o_load_done,
   output logic                                 o_load_error,
   input  logic                                 i_rd_en,
   input  logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0] i_rd_address [0:KERNEL_BRAM_NUM-1],
   output logic [DATA_WIDTH-1:0]                o_rd_data [0:KERNEL_BRAM_NUM-1],
   output logic                                 o_rd_valid
);
   localparam int AW = KERNEL_BRAM_ADDRESS_WIDTH;
   localparam int LOG2N = log2_banks(KERNEL_BRAM_NUM);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(KERNEL_BRAM_NUM * (2 ** AW));
   localparam logic [LEN_WIDTH-1:0] BANK_MASK = LEN_WIDTH'(KERNEL_BRAM_NUM - 1);
   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

   state_t state_q, state_d;
   mode_t mode_q, mode_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, bank_sel;
   logic done_q, done_d, err_q, err_d, wr_en, rd_acc, rd_v1;
   logic [AW-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] bank_rd [0:KERNEL_BRAM_NUM-1];

   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_INTERLEAVE;
         cnt_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_v1   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rd_v1   <= rd_acc;
      end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (state_q == ST_LOAD) begin
         if (i_wvalid) begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == len_q - ONE) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
      end else if (i_load_start) begin
         if (i_load_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else if (i_load_len > MAX_LEN) begin
            err_d = 1'b1;
         end else begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            len_d   = i_load_len;
            mode_d  = mode_t'(i_load_mode);
         end
      end
   end

   assign o_wready     = state_q == ST_LOAD;
   assign o_busy       = state_q == ST_LOAD;
   assign o_load_done  = done_q;
   assign o_load_error = err_q;
   assign wr_en        = o_wready && i_wvalid;
   assign rd_acc       = i_rd_en && state_q != ST_LOAD;
   // Interleaved: low counter bits pick the bank; sequential: high bits do.
   assign bank_sel = (mode_q == MODE_SEQUENTIAL) ? cnt_q >> AW : cnt_q & BANK_MASK;
   assign wr_addr  = (mode_q == MODE_SEQUENTIAL) ? AW'(cnt_q) : AW'(cnt_q >> LOG2N);

   for (genvar g = 0; g < KERNEL_BRAM_NUM; g++) begin : g_bank
      kernel_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DATA_WIDTH)) u_bank (
         .i_clock(i_clock),
         .i_reset(i_reset),
         .i_we(wr_en && bank_sel == LEN_WIDTH'(g)),
         .i_waddr(wr_addr),
         .i_wdata(i_wdata),
         .i_re(rd_acc),
         .i_raddr(i_rd_address[g]),
         .o_rdata(bank_rd[g])
      );
   end

   if (READ_LATENCY == 2) begin : g_out_reg
      logic rd_v2;
      logic [DATA_WIDTH-1:0] rd_q [0:KERNEL_BRAM_NUM-1];
      always_ff @(posedge i_clock or posedge i_reset)
         if (i_reset) begin
            rd_v2 <= 1'b0;
            rd_q  <= '{default: '0};
         end else begin
            rd_v2 <= rd_v1;
            if (rd_v1) rd_q <= bank_rd;
         end
      assign o_rd_valid = rd_v2;
      assign o_rd_data  = rd_q;
   end else begin : g_no_out_reg
      assign o_rd_valid = rd_v1;
      assign o_rd_data  = bank_rd;
   end
endmodule

// File: tb/tb_kernel_mem_loader.sv
// tb_kernel_mem_loader: directed, table-driven bench for the banked kernel store (N=4, AW=4).
module tb_kernel_mem_loader;
   logic clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_load_start = 1'b0, i_load_mode = 1'b0, i_wvalid = 1'b0, i_rd_en = 1'b0;
   logic [6:0] i_load_len = '0;
   logic [31:0] i_wdata = '0;
   logic [3:0] i_rd_address [0:3] = '{default: '0};
   logic [31:0] o_rd_data [0:3];
   logic o_wready, o_busy, o_load_done, o_load_error, o_rd_valid;
   int errors = 0, checks = 0;

   typedef struct {
      logic [15:0]  a;
      logic [127:0] e;
      logic [3:0]   m;
   } vec_t;
   vec_t vt [5];
   vec_t bb [4];

   kernel_mem_loader #(.KERNEL_BRAM_NUM(4), .KERNEL_BRAM_ADDRESS_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_load_start(i_load_start), .i_load_mode(i_load_mode),
      .i_load_len(i_load_len), .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_load_done(o_load_done), .o_load_error(o_load_error), .i_rd_en(i_rd_en),
      .i_rd_address(i_rd_address), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outputs_zero(input string nm);
      chk({nm, " wready"}, 32'(o_wready), 0);
      chk({nm, " busy"}, 32'(o_busy), 0);
      chk({nm, " done"}, 32'(o_load_done), 0);
      chk({nm, " error"}, 32'(o_load_error), 0);
      chk({nm, " rd_valid"}, 32'(o_rd_valid), 0);
      for (int b = 0; b < 4; b++) chk($sformatf("%s rd_data%0d", nm, b), o_rd_data[b], 0);
   endtask

   task automatic start_load(input logic [6:0] len, input logic mode);
      i_load_start = 1'b1;
      i_load_len = len;
      i_load_mode = mode;
      tick();
      i_load_start = 1'b0;
   endtask

   task automatic stream(input string nm, input int len, input int base, input logic [3:0] pat, input logic hold_rd);
      int hs = 0, dcnt = 0, dbad = 0, vcnt = 0, c = 0;
      logic v, fire, last;
      chk({nm, " busy"}, 32'(o_busy), 1);
      i_rd_en = hold_rd;
      while (hs < len && c < 200) begin
         v = pat[c % 4];
         i_wvalid = v;
         i_wdata = v ? 32'(base + hs) : 32'hdead_beef;
         fire = v && o_wready;
         last = fire && (hs == len - 1);
         tick();
         if (fire) hs++;
         if (o_load_done) dcnt++;
         if (o_load_done !== last) dbad++;
         if (o_rd_valid) vcnt++;
         c++;
      end
      i_wvalid = 1'b0;
      i_rd_en = 1'b0;
      chk({nm, " handshakes"}, 32'(hs), 32'(len));
      chk({nm, " done pulses"}, 32'(dcnt), 1);
      chk({nm, " done timing"}, 32'(dbad), 0);
      chk({nm, " wready after"}, 32'(o_wready), 0);
      chk({nm, " busy after"}, 32'(o_busy), 0);
      if (hold_rd) chk({nm, " rd_valid in load"}, 32'(vcnt), 0);
      tick();
      chk({nm, " done low"}, 32'(o_load_done), 0);
      if (hold_rd) chk({nm, " rd_valid after"}, 32'(o_rd_valid), 0);
   endtask

   task automatic rd_check(input string nm, input logic [15:0] a, input logic [127:0] e, input logic [3:0] m);
      i_rd_en = 1'b1;
      for (int b = 0; b < 4; b++) i_rd_address[b] = a[4*b +: 4];
      tick();
      i_rd_en = 1'b0;
      chk({nm, " valid early"}, 32'(o_rd_valid), 0);
      tick();
      chk({nm, " valid"}, 32'(o_rd_valid), 1);
      for (int b = 0; b < 4; b++) if (m[b]) chk($sformatf("%s data%0d", nm, b), o_rd_data[b], e[32*b +: 32]);
      tick();
      chk({nm, " valid late"}, 32'(o_rd_valid), 0);
      for (int b = 0; b < 4; b++) if (m[b]) chk($sformatf("%s hold%0d", nm, b), o_rd_data[b], e[32*b +: 32]);
   endtask

   initial begin
      // Contents after the interleaved (0..7) then sequential (100..119) loads.
      vt[0] = '{a: {4'd3, 4'd3, 4'd3, 4'd3}, e: {32'd0, 32'd0, 32'd119, 32'd103}, m: 4'b0011};
      vt[1] = '{a: {4'd0, 4'd0, 4'd0, 4'd0}, e: {32'd3, 32'd2, 32'd116, 32'd100}, m: 4'b1111};
      vt[2] = '{a: {4'd1, 4'd1, 4'd1, 4'd1}, e: {32'd7, 32'd6, 32'd117, 32'd101}, m: 4'b1111};
      vt[3] = '{a: {4'd1, 4'd0, 4'd2, 4'd15}, e: {32'd7, 32'd2, 32'd118, 32'd115}, m: 4'b1111};
      vt[4] = '{a: {4'd0, 4'd1, 4'd0, 4'd8}, e: {32'd3, 32'd6, 32'd116, 32'd108}, m: 4'b1111};
      // Contents at the end of the run, read back-to-back.
      bb[0] = '{a: {4'd0, 4'd0, 4'd0, 4'd0}, e: {32'd603, 32'd602, 32'd601, 32'd600}, m: 4'b1111};
      bb[1] = '{a: {4'd1, 4'd1, 4'd1, 4'd1}, e: {32'd349, 32'd333, 32'd317, 32'd501}, m: 4'b1111};
      bb[2] = '{a: {4'd15, 4'd15, 4'd15, 4'd15}, e: {32'd363, 32'd347, 32'd331, 32'd315}, m: 4'b1111};
      bb[3] = '{a: {4'd0, 4'd9, 4'd5, 4'd2}, e: {32'd603, 32'd341, 32'd321, 32'd502}, m: 4'b1111};

      tick();
      outputs_zero("reset");
      tick();
      i_reset = 1'b0;
      tick();

      start_load(7'd8, 1'b0);
      stream("interleave", 8, 0, 4'b1111, 1'b0);
      rd_check("il a1", {4'd1, 4'd1, 4'd1, 4'd1}, {32'd7, 32'd6, 32'd5, 32'd4}, 4'b1111);

      start_load(7'd20, 1'b1);
      stream("sequential", 20, 100, 4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) rd_check($sformatf("vec%0d", i), vt[i].a, vt[i].e, vt[i].m);
      for (int a = 0; a < 16; a++)
         rd_check($sformatf("seq b0 a%0d", a), {12'd0, 4'(a)}, {96'd0, 32'(100 + a)}, 4'b0001);

      start_load(7'd6, 1'b0);
      stream("backpressure", 6, 200, 4'b1001, 1'b0);
      rd_check("bp a0", {4'd0, 4'd0, 4'd0, 4'd0}, {32'd203, 32'd202, 32'd201, 32'd200}, 4'b1111);
      rd_check("bp a1", {4'd1, 4'd1, 4'd1, 4'd1}, {32'd7, 32'd6, 32'd205, 32'd204}, 4'b1111);

      start_load(7'd65, 1'b0);
      chk("len65 error", 32'(o_load_error), 1);
      chk("len65 done", 32'(o_load_done), 0);
      chk("len65 wready", 32'(o_wready), 0);
      chk("len65 busy", 32'(o_busy), 0);
      tick();
      chk("len65 error low", 32'(o_load_error), 0);
      chk("len65 wready later", 32'(o_wready), 0);
      chk("len65 busy later", 32'(o_busy), 0);

      start_load(7'd0, 1'b0);
      chk("len0 done", 32'(o_load_done), 1);
      chk("len0 busy", 32'(o_busy), 0);
      chk("len0 wready", 32'(o_wready), 0);
      tick();
      chk("len0 done low", 32'(o_load_done), 0);
      rd_check("len0 nowrite", {4'd1, 4'd1, 4'd1, 4'd1}, {32'd7, 32'd6, 32'd205, 32'd204}, 4'b1111);

      start_load(7'd64, 1'b1);
      stream("full", 64, 300, 4'b1111, 1'b0);
      rd_check("full a0", {4'd0, 4'd0, 4'd0, 4'd0}, {32'd348, 32'd332, 32'd316, 32'd300}, 4'b1111);
      rd_check("full a15", {4'd15, 4'd15, 4'd15, 4'd15}, {32'd363, 32'd347, 32'd331, 32'd315}, 4'b1111);

      start_load(7'd10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         i_wvalid = 1'b1;
         i_wdata = 32'(400 + k);
         tick();
      end
      i_wvalid = 1'b0;
      chk("midload wready", 32'(o_wready), 1);
      i_reset = 1'b1;
      #1;
      outputs_zero("midload reset");
      tick();
      i_reset = 1'b0;
      tick();
      start_load(7'd4, 1'b1);
      stream("reload", 4, 500, 4'b1111, 1'b0);
      rd_check("reload a0", {4'd0, 4'd0, 4'd0, 4'd0}, {32'd348, 32'd402, 32'd401, 32'd500}, 4'b1111);

      start_load(7'd4, 1'b0);
      stream("rd in load", 4, 600, 4'b1111, 1'b1);

      for (int c = 0; c < 7; c++) begin
         i_rd_en = c < 4;
         if (c < 4) for (int b = 0; b < 4; b++) i_rd_address[b] = bb[c].a[4*b +: 4];
         tick();
         if (c >= 1 && c <= 4) begin
            chk($sformatf("b2b%0d valid", c - 1), 32'(o_rd_valid), 1);
            for (int b = 0; b < 4; b++)
               chk($sformatf("b2b%0d data%0d", c - 1, b), o_rd_data[b], bb[c-1].e[32*b +: 32]);
         end else begin
            chk($sformatf("b2b idle%0d valid", c), 32'(o_rd_valid), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/kernel_mem_loader.md
Name: kernel_mem_loader

Overview:
- Parametrised banked kernel-weight store: KERNEL_BRAM_NUM inferred simple-dual-port banks plus a streaming write loader that scatters an incoming weight stream across the banks.
- Two fill modes: interleaved (word k to bank k mod N) or sequential (bank-by-bank fill).
- Read side takes one address per bank and returns all banks in parallel, with a read-valid aligned to a configurable read latency.
- Sits between the DMA/weight stream and the convolution PE array.

Parameters:
- KERNEL_BRAM_NUM, 4, number of banks; must be a power of two, at least 1.
- KERNEL_BRAM_ADDRESS_WIDTH, 16, per-bank address width; DEPTH = 2**KERNEL_BRAM_ADDRESS_WIDTH.
- DATA_WIDTH, 32, word width.
- READ_LATENCY, 2, cycles from i_rd_en to o_rd_valid; legal values 1 or 2. A value of 2 adds an output register.
- LEN_WIDTH, derived, clog2(KERNEL_BRAM_NUM*DEPTH)+1.

Ports:
- i_clock  in  1  single clock for all logic.
- i_reset  in  1  asynchronous, active-high reset.
- i_load_start  in  1  one-cycle pulse; starts a load when in IDLE or DONE.
- i_load_mode  in  1  0 = interleaved, 1 = sequential; sampled with i_load_start.
- i_load_len  in  LEN_WIDTH  number of words to load; sampled with i_load_start.
- i_wvalid  in  1  write-stream valid.
- o_wready  out  1  write-stream ready.
- i_wdata  in  DATA_WIDTH  write-stream data.
- o_busy  out  1  high while in LOAD.
- o_load_done  out  1  one-cycle pulse when the last word is written.
- o_load_error  out  1  one-cycle pulse when i_load_len is illegal.
- i_rd_en  in  1  read request, applied to all banks.
- i_rd_address  in  [KERNEL_BRAM_ADDRESS_WIDTH-1:0] x [0:KERNEL_BRAM_NUM-1]  per-bank read address.
- o_rd_data  out  [DATA_WIDTH-1:0] x [0:KERNEL_BRAM_NUM-1]  per-bank read data.
- o_rd_valid  out  1  o_rd_data is valid.

Behaviour:
- Reset values: state IDLE, word counter 0, all read-valid pipeline stages 0. Every output is 0 during reset, including o_rd_data. Bank contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE or DONE, on i_load_start:
  - len = 0: go to DONE and pulse o_load_done the next cycle.
  - len > N*DEPTH: pulse o_load_error the next cycle and stay in the current state.
  - otherwise: latch len and mode, clear the counter, go to LOAD.
- LOAD:
  - o_wready = 1 and o_busy = 1.
  - A handshake occurs when i_wvalid and o_wready are both high. Each handshake writes i_wdata and increments the counter; the counter does not move without a handshake.
  - Address generation, interleaved: bank = cnt[log2N-1:0], addr = cnt >> log2N.
  - Address generation, sequential: bank = cnt >> KERNEL_BRAM_ADDRESS_WIDTH, addr = cnt low bits.
  - The write of word len-1 completes the load: state goes to DONE, o_load_done pulses in the following cycle, and o_wready deasserts in that same cycle.
- i_load_start during LOAD is ignored.
- DONE behaves as IDLE except that it records that a load completed.
- Reads:
  - Accepted only in IDLE or DONE. i_rd_en during LOAD is dropped and produces no o_rd_valid.
  - All banks read in parallel. o_rd_valid asserts exactly READ_LATENCY cycles after an accepted i_rd_en, for one cycle per request.
  - Back-to-back reads are fully pipelined, one per cycle.
  - o_rd_data holds its last value while o_rd_valid = 0.
- Bank RAM: write-first is not required, because reads and writes never overlap.
- Reset mid-LOAD: returns to IDLE immediately and asynchronously. Words already written stay in the banks, and a new i_load_start restarts from counter 0.

Decomposition:
- Package kernel_mem_pkg holds:
  - the FSM state enum;
  - localparam helpers for LEN_WIDTH and log2 of the bank count;
  - the fill-mode enum: MODE_INTERLEAVE = 0, MODE_SEQUENTIAL = 1.
- Sub-module kernel_bank: inferred simple-dual-port RAM with one write port and one registered read port. Instantiated KERNEL_BRAM_NUM times in a generate loop.
- The top level contains the FSM, the address generator and the valid pipeline.

Test Plan (N=4, AW=4, DEPTH=16, DW=32, READ_LATENCY=2):
- Interleaved load: len=8, data 0..7 with continuous valid. Then read address 1 on all banks → after 2 cycles o_rd_data = {4,5,6,7} with o_rd_valid high for 1 cycle. o_load_done pulses once, after the 8th handshake.
- Sequential load: len=20, data 100..119. Read address 3 on all banks → {103, 119, x, x}. Check bank0 addresses 0..15 = 100..115 and bank1 address 3 = 119.
- Backpressure: i_wvalid toggles 1,0,0,1,… during a len=6 load → exactly 6 writes, correct addresses, o_load_done only after the 6th accepted word.
- Boundaries:
  - len=65 → o_load_error pulse, o_wready stays 0, o_busy stays 0.
  - len=64 → banks full, done.
  - len=0 → o_load_done the next cycle with no writes.
- Reset mid-load after 3 words → all outputs 0 and state IDLE. A new len=4 load then completes normally.
- i_rd_en held during LOAD → o_rd_valid stays 0. Four back-to-back reads in DONE → four consecutive o_rd_valid cycles with correct data.
